// File: rtl/ftdi_sync_fifo_tx_if.sv
// ---------------------------------------------------------------------------
// ftdi_sync_fifo_tx_if
//   Signal bundle between an upstream byte FIFO read controller, the
//   ftdi_sync_fifo_tx bridge and an FT232H in synchronous-FIFO mode.
//
//   Handshake semantics (all sampled on the rising edge of CLKOUT):
//     upstream : fifo_rdreq may be asserted only while ftdi_rx_rdy=1; the byte
//                on fifo_q belongs to that request and is valid exactly one
//                cycle after it. A request seen while ftdi_rx_rdy=0 is ignored.
//     device   : a byte transfers on an edge iff ftdi_wr_n=0 and ftdi_txe_n=0;
//                ftdi_d holds that byte while ftdi_wr_n=0. If ftdi_txe_n is
//                high at the edge, nothing transfers and the byte is retried.
//
//   Modports:
//     master : upstream FIFO / device model side (drives fifo_q, fifo_rdreq,
//              ftdi_txe_n)
//     slave  : the bridge (drives ftdi_rx_rdy, ftdi_wr_n, ftdi_d, ftdi_rd_n,
//              ftdi_oe_n)
// ---------------------------------------------------------------------------
interface ftdi_sync_fifo_tx_if;
  logic [7:0] fifo_q;
  logic       fifo_rdreq;
  logic       ftdi_rx_rdy;
  logic       ftdi_txe_n;
  logic       ftdi_wr_n;
  logic [7:0] ftdi_d;
  logic       ftdi_rd_n;
  logic       ftdi_oe_n;

  modport master (
    output fifo_q, fifo_rdreq, ftdi_txe_n,
    input  ftdi_rx_rdy, ftdi_wr_n, ftdi_d, ftdi_rd_n, ftdi_oe_n
  );

  modport slave (
    input  fifo_q, fifo_rdreq, ftdi_txe_n,
    output ftdi_rx_rdy, ftdi_wr_n, ftdi_d, ftdi_rd_n, ftdi_oe_n
  );
endinterface

// File: rtl/ftdi_sync_fifo_tx.sv
// ---------------------------------------------------------------------------
// ftdi_sync_fifo_tx
//   Transmit bridge from an upstream byte FIFO (1-cycle read latency) to an
//   FT232H synchronous FIFO. A small skid buffer absorbs the bytes already in
//   flight when the device deasserts TXE#, so no byte is lost or duplicated.
//
// Parameters:
//   BUF_DEPTH : skid-buffer entries, power of two, >= 4
//
// Ports:
//   clk  : FT232H CLKOUT (60 MHz), all logic on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : ftdi_sync_fifo_tx_if.slave (fifo_q, fifo_rdreq, ftdi_rx_rdy,
//          ftdi_txe_n, ftdi_wr_n, ftdi_d, ftdi_rd_n, ftdi_oe_n)
//
// Optional build macro FTDI_TX_STAT_EN adds:
//   tx_byte_cnt[31:0]   : bytes accepted by the device, wraps
//   txe_stall_cnt[15:0] : cycles with data buffered while TXE# high, saturates
// ---------------------------------------------------------------------------
module ftdi_sync_fifo_tx #(
  parameter int BUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  ftdi_sync_fifo_tx_if.slave        bus
`ifdef FTDI_TX_STAT_EN
  ,
  output logic [31:0]               tx_byte_cnt,
  output logic [15:0]               txe_stall_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    r_mem [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_pend;
  logic          r_wr_n;
  logic [7:0]    r_d;

  logic          w_rx_rdy;
  logic          w_pop;
  logic          w_push;
  logic [LW-1:0] w_level_nxt;
  logic [LW-1:0] w_kept;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [7:0]    w_head_nxt;

  // Ready only while two more bytes fit: one may already be pending from the
  // previous request and another may be requested on this edge.
  assign w_rx_rdy = ({1'b0, r_level} + {{LW{1'b0}}, r_pend})
                    <= (LW+1)'(BUF_DEPTH - 2);

  assign w_pop  = ~r_wr_n & ~bus.ftdi_txe_n & (r_level != '0);
  // A full buffer can still take a byte on an edge that also pops.
  assign w_push = r_pend & ((r_level != LW'(BUF_DEPTH)) | w_pop);

  assign w_level_nxt  = r_level + {{(LW-1){1'b0}}, w_push}
                                - {{(LW-1){1'b0}}, w_pop};
  assign w_rd_ptr_nxt = r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
  assign w_kept       = r_level - {{(LW-1){1'b0}}, w_pop};
  // When no older byte survives this edge the new head is the byte being
  // written right now, so bypass the memory.
  assign w_head_nxt   = (w_kept == '0) ? bus.fifo_q : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_pend   <= 1'b0;
      r_wr_n   <= 1'b1;
      r_d      <= 8'h00;
    end else begin
      r_pend   <= bus.fifo_rdreq & w_rx_rdy;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_wr_n   <= ~((w_level_nxt != '0) & ~bus.ftdi_txe_n);
      if (w_level_nxt != '0) r_d <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.fifo_q;
  end

  assign bus.ftdi_rx_rdy = w_rx_rdy;
  assign bus.ftdi_wr_n   = r_wr_n;
  assign bus.ftdi_d      = r_d;
  assign bus.ftdi_rd_n   = 1'b1;
  assign bus.ftdi_oe_n   = 1'b1;

`ifdef FTDI_TX_STAT_EN
  logic [31:0] r_tx_byte_cnt;
  logic [15:0] r_txe_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_byte_cnt   <= '0;
      r_txe_stall_cnt <= '0;
    end else begin
      if (w_pop) r_tx_byte_cnt <= r_tx_byte_cnt + 32'd1;
      if ((r_level != '0) && bus.ftdi_txe_n && (r_txe_stall_cnt != 16'hFFFF))
        r_txe_stall_cnt <= r_txe_stall_cnt + 16'd1;
    end
  end

  assign tx_byte_cnt   = r_tx_byte_cnt;
  assign txe_stall_cnt = r_txe_stall_cnt;
`endif

endmodule
